// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped 8-digit 7-segment display controller.
// Holds a DATA word (one hex nibble per digit) and a CTRL word (enable mask,
// dp mask, global blank). Digits are scanned with a free-running counter and
// all display outputs are registered and active-low.
// Optional build macro: SEG7_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic                    sel_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_o,
    output logic [NUM_DIGITS-1:0]   led_en_o,
    output logic                    led_ca_o,
    output logic                    led_cb_o,
    output logic                    led_cc_o,
    output logic                    led_cd_o,
    output logic                    led_ce_o,
    output logic                    led_cf_o,
    output logic                    led_cg_o,
    output logic                    led_dp_o
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [16:0]             ctrl_q, ctrl_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   led_en_q, led_en_d;
    logic [6:0]              seg_q, seg_d;   // {g,f,e,d,c,b,a}, active-low
    logic                    dp_q, dp_d;

    logic [3:0]              nibble;
    logic [6:0]              seg_lit;        // {g,f,e,d,c,b,a}, 1 = lit
    logic [7:0]              en_mask, dp_mask;
    logic                    lz_blank;
    logic                    blank;

    // State registers: config, scan position and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            ctrl_q   <= 17'h000FF;
            cnt_q    <= '0;
            idx_q    <= '0;
            led_en_q <= '1;
            seg_q    <= '1;
            dp_q     <= 1'b1;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            led_en_q <= led_en_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    // Register writes and scan counter; writes never touch cnt/idx
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (we_i) begin
            if (sel_i) begin
                ctrl_d = wdata_i[16:0];
            end else begin
                data_d = wdata_i;
            end
        end
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = idx_q + IdxW'(1);
        end else begin
            cnt_d = cnt_q + CntW'(1);
            idx_d = idx_q;
        end
    end

    // Hex to segment decode of the currently scanned nibble
    always_comb begin
        nibble  = data_q[{idx_q, 2'b00} +: 4];
        seg_lit = 7'h00;
        case (nibble)
            4'h0: seg_lit = 7'h3F;
            4'h1: seg_lit = 7'h06;
            4'h2: seg_lit = 7'h5B;
            4'h3: seg_lit = 7'h4F;
            4'h4: seg_lit = 7'h66;
            4'h5: seg_lit = 7'h6D;
            4'h6: seg_lit = 7'h7D;
            4'h7: seg_lit = 7'h07;
            4'h8: seg_lit = 7'h7F;
            4'h9: seg_lit = 7'h6F;
            4'hA: seg_lit = 7'h77;
            4'hB: seg_lit = 7'h7C;
            4'hC: seg_lit = 7'h39;
            4'hD: seg_lit = 7'h5E;
            4'hE: seg_lit = 7'h79;
            4'hF: seg_lit = 7'h71;
            default: seg_lit = 7'h00;
        endcase
    end

    // Blanking and next display outputs for the current digit
    always_comb begin
        en_mask = ctrl_q[7:0];
        dp_mask = ctrl_q[15:8];
`ifdef SEG7_LZ_SUPPRESS_EN
        // Blank when this nibble and every higher one are zero; digit 0 always shows
        lz_blank = (idx_q != '0) && ((data_q >> {idx_q, 2'b00}) == '0);
`else
        lz_blank = 1'b0;
`endif
        blank = ctrl_q[16] | ~en_mask[idx_q] | lz_blank;
        if (blank) begin
            led_en_d = '1;
            seg_d    = '1;
            dp_d     = 1'b1;
        end else begin
            led_en_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d    = ~seg_lit;
            dp_d     = ~dp_mask[idx_q];
        end
    end

    // Combinational register read; reserved CTRL bits read as zero
    always_comb begin
        rdata_o = sel_i ? {15'b0, ctrl_q} : data_q;
    end

    assign led_en_o = led_en_q;
    assign led_ca_o = seg_q[0];
    assign led_cb_o = seg_q[1];
    assign led_cc_o = seg_q[2];
    assign led_cd_o = seg_q[3];
    assign led_ce_o = seg_q[4];
    assign led_cf_o = seg_q[5];
    assign led_cg_o = seg_q[6];
    assign led_dp_o = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl with SCAN_DIV = 4.
// Expected patterns are {dp,g,f,e,d,c,b,a}, active-low.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        we_i;
    logic        sel_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic [7:0]  led_en_o;
    logic        led_ca_o, led_cb_o, led_cc_o, led_cd_o;
    logic        led_ce_o, led_cf_o, led_cg_o, led_dp_o;
    logic [7:0]  pat_obs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Hand-decoded patterns for DATA = 0x0123ABCF, digits 0..7 (F,C,b,A,3,2,1,0)
    logic [7:0] data_pat [8] = '{8'h8E, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

    seg7_scan_ctrl #(
        .SCAN_DIV   (4),
        .NUM_DIGITS (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we_i),
        .sel_i    (sel_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .led_en_o (led_en_o),
        .led_ca_o (led_ca_o),
        .led_cb_o (led_cb_o),
        .led_cc_o (led_cc_o),
        .led_cd_o (led_cd_o),
        .led_ce_o (led_ce_o),
        .led_cf_o (led_cf_o),
        .led_cg_o (led_cg_o),
        .led_dp_o (led_dp_o)
    );

    assign pat_obs = {led_dp_o, led_cg_o, led_cf_o, led_ce_o,
                      led_cd_o, led_cc_o, led_cb_o, led_ca_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic s, input logic [31:0] d);
        sel_i   = s;
        wdata_i = d;
        we_i    = 1'b1;
        step();
        we_i    = 1'b0;
    endtask

    // Digit shown after edge n (edges counted from reset release)
    function automatic int dig_at(input int n);
        return ((n - 1) / 4) % 8;
    endfunction

    function automatic logic [7:0] en_at(input int n);
        logic [7:0] one = 8'h01;
        return ~(one << dig_at(n));
    endfunction

    // Expected outputs with DATA = 0x0123ABCF and all digits enabled
    function automatic logic [7:0] exp_en_norm(input int n);
`ifdef SEG7_LZ_SUPPRESS_EN
        if (dig_at(n) == 7) return 8'hFF;
`endif
        return en_at(n);
    endfunction

    function automatic logic [7:0] exp_pat_norm(input int n, input bit dp1);
        int d = dig_at(n);
        logic [7:0] p = data_pat[d];
`ifdef SEG7_LZ_SUPPRESS_EN
        if (d == 7) p = 8'hFF;
`endif
        if (dp1 && d == 1) p = p & 8'h7F;
        return p;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        we_i    = 1'b0;
        sel_i   = 1'b0;
        wdata_i = '0;
        #12;
        n_checks++;
        if (led_en_o !== 8'hFF) begin
            n_fail++; $display("FAIL reset_en: got %h expected ff", led_en_o);
        end
        n_checks++;
        if (pat_obs !== 8'hFF) begin
            n_fail++; $display("FAIL reset_pat: got %h expected ff", pat_obs);
        end
        n_checks++;
        if (rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", rdata_o);
        end
        sel_i = 1'b1;
        #1;
        n_checks++;
        if (rdata_o !== 32'hFF) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected ff", rdata_o);
        end
        sel_i = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_scan();
        for (int k = 0; k < 40; k++) begin
            step();
            n_checks++;
            if (led_en_o !== en_at(cyc)) begin
                n_fail++;
                $display("FAIL scan_en cyc=%0d: got %h expected %h", cyc, led_en_o, en_at(cyc));
            end
            n_checks++;
            if (pat_obs !== 8'hC0) begin
                n_fail++; $display("FAIL scan_pat cyc=%0d: got %h expected c0", cyc, pat_obs);
            end
        end
    endtask

    task automatic test_data();
        wr(1'b0, 32'h0123ABCF);
        step();
        for (int k = 0; k < 32; k++) begin
            step();
            n_checks++;
            if (led_en_o !== exp_en_norm(cyc) || pat_obs !== exp_pat_norm(cyc, 1'b0)) begin
                n_fail++;
                $display("FAIL data cyc=%0d: got en=%h pat=%h expected en=%h pat=%h", cyc,
                         led_en_o, pat_obs, exp_en_norm(cyc), exp_pat_norm(cyc, 1'b0));
            end
        end
    endtask

    task automatic test_ctrl();
        logic [7:0] ee, ep;
        wr(1'b1, 32'h0000_0205);
        n_checks++;
        if (rdata_o !== 32'h0000_0205) begin
            n_fail++; $display("FAIL ctrl_read: got %h expected 00000205", rdata_o);
        end
        sel_i = 1'b0;
        step();
        for (int k = 0; k < 32; k++) begin
            step();
            if (dig_at(cyc) == 0 || dig_at(cyc) == 2) begin
                ee = en_at(cyc);
                ep = data_pat[dig_at(cyc)];
            end else begin
                ee = 8'hFF;
                ep = 8'hFF;
            end
            n_checks++;
            if (led_en_o !== ee || pat_obs !== ep) begin
                n_fail++;
                $display("FAIL ctrl_mask cyc=%0d: got en=%h pat=%h expected en=%h pat=%h", cyc,
                         led_en_o, pat_obs, ee, ep);
            end
        end
    endtask

    task automatic test_blank();
        wr(1'b1, 32'hFFFE_00FF);
        n_checks++;
        if (rdata_o !== 32'h0000_00FF) begin
            n_fail++; $display("FAIL ctrl_reserved: got %h expected 000000ff", rdata_o);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (led_en_o !== exp_en_norm(cyc) || pat_obs !== exp_pat_norm(cyc, 1'b0)) begin
                n_fail++;
                $display("FAIL pre_blank cyc=%0d: got en=%h pat=%h", cyc, led_en_o, pat_obs);
            end
        end
        // Output on the write edge still reflects the old CTRL
        wr(1'b1, 32'h0001_00FF);
        n_checks++;
        if (led_en_o !== exp_en_norm(cyc) || pat_obs !== exp_pat_norm(cyc, 1'b0)) begin
            n_fail++;
            $display("FAIL blank_edge cyc=%0d: got en=%h pat=%h", cyc, led_en_o, pat_obs);
        end
        n_checks++;
        if (rdata_o !== 32'h0001_00FF) begin
            n_fail++; $display("FAIL blank_read: got %h expected 000100ff", rdata_o);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (led_en_o !== 8'hFF || pat_obs !== 8'hFF) begin
                n_fail++;
                $display("FAIL blank cyc=%0d: got en=%h pat=%h expected ff/ff", cyc, led_en_o,
                         pat_obs);
            end
        end
        // Clear blank and light the dp on digit 1
        wr(1'b1, 32'h0000_02FF);
        n_checks++;
        if (led_en_o !== 8'hFF || pat_obs !== 8'hFF) begin
            n_fail++;
            $display("FAIL unblank_edge cyc=%0d: got en=%h pat=%h expected ff/ff", cyc,
                     led_en_o, pat_obs);
        end
        sel_i = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step();
            n_checks++;
            if (led_en_o !== exp_en_norm(cyc) || pat_obs !== exp_pat_norm(cyc, 1'b1)) begin
                n_fail++;
                $display("FAIL unblank cyc=%0d: got en=%h pat=%h expected en=%h pat=%h", cyc,
                         led_en_o, pat_obs, exp_en_norm(cyc), exp_pat_norm(cyc, 1'b1));
            end
        end
    endtask

    task automatic test_write_live();
        for (int k = 0; k < 64 && (cyc % 32) != 1; k++) step();
        n_checks++;
        if ((cyc % 32) != 1 || led_en_o !== 8'hFE) begin
            n_fail++; $display("FAIL live_sync cyc=%0d: got en=%h expected fe", cyc, led_en_o);
        end
        wr(1'b0, 32'h0123ABC5);
        n_checks++;
        if (led_en_o !== 8'hFE || pat_obs !== 8'h8E) begin
            n_fail++;
            $display("FAIL live_old cyc=%0d: got en=%h pat=%h expected fe/8e", cyc, led_en_o,
                     pat_obs);
        end
        step();
        n_checks++;
        if (led_en_o !== 8'hFE || pat_obs !== 8'h92) begin
            n_fail++;
            $display("FAIL live_new cyc=%0d: got en=%h pat=%h expected fe/92", cyc, led_en_o,
                     pat_obs);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            n_checks++;
            if (led_en_o !== en_at(cyc)) begin
                n_fail++;
                $display("FAIL live_phase cyc=%0d: got %h expected %h", cyc, led_en_o,
                         en_at(cyc));
            end
            if (dig_at(cyc) == 0) begin
                n_checks++;
                if (pat_obs !== 8'h92) begin
                    n_fail++; $display("FAIL live_pat cyc=%0d: got %h expected 92", cyc, pat_obs);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] ee, ep;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led_en_o !== 8'hFF || pat_obs !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_dark: got en=%h pat=%h expected ff/ff", led_en_o, pat_obs);
        end
        sel_i = 1'b0;
        #1;
        n_checks++;
        if (rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL async_data: got %h expected 0", rdata_o);
        end
        sel_i = 1'b1;
        #1;
        n_checks++;
        if (rdata_o !== 32'hFF) begin
            n_fail++; $display("FAIL async_ctrl: got %h expected ff", rdata_o);
        end
        sel_i = 1'b0;
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            ee = en_at(cyc);
            ep = 8'hC0;
`ifdef SEG7_LZ_SUPPRESS_EN
            if (dig_at(cyc) != 0) begin
                ee = 8'hFF;
                ep = 8'hFF;
            end
`endif
            n_checks++;
            if (led_en_o !== ee || pat_obs !== ep) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d: got en=%h pat=%h expected en=%h pat=%h", cyc,
                         led_en_o, pat_obs, ee, ep);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_data();
        test_ctrl();
        test_blank();
        test_write_live();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Memory-mapped 8-digit, 7-segment LED display controller that sits on the device side of the system bus, downstream of the CPU/bus address decoder. It holds a 32-bit hex display word and a control word written by the CPU, time-multiplexes the eight digits with a free-running scan counter, and drives the board's active-low digit enables and segment lines. It replaces ad-hoc display logic so that software only writes a value and the hardware refreshes it continuously.

## Interface
- SCAN_DIV, 100000: clk cycles each digit is held before advancing; legal range 2..2^20.
- NUM_DIGITS, 8: number of digits; fixed at 8, and the data word is 4×NUM_DIGITS bits.

- clk  in  1  system clock (CPU clock domain)
- rst_n  in  1  reset; asynchronous, active-low
- we  in  1  register write strobe, one cycle per write
- sel  in  1  register select: 0 = DATA, 1 = CTRL
- wdata  in  32  write data
- rdata  out  32  read data of the selected register (combinational)
- led_en  out  8  digit enables, active-low; bit i selects digit i
- led_ca..led_cg  out  1 each  segments a..g, active-low
- led_dp  out  1  decimal point, active-low

## Operation
- DATA register, 32 bits: digit i displays nibble DATA[4i+3:4i] as hex 0–F.
- CTRL register: [7:0] digit enable mask (1 = on), [15:8] dp mask (1 = dot lit), [16] global blank (1 = all off), [31:17] reserved. Reserved bits read as 0 and ignore writes.
- A write with we=1 updates the register selected by sel at that clk edge. Reads never have side effects.
- Scan counter cnt counts 0..SCAN_DIV-1. When cnt = SCAN_DIV-1, cnt wraps to 0 and digit index idx advances, wrapping 7 → 0.
- Digit i is blank when CTRL[16]=1, CTRL[i]=0, or (with the macro enabled) leading-zero suppression applies.
- A blank digit drives led_en all 1s, segments all 1s, and led_dp=1.
- A non-blank digit drives led_en = ~(1<<idx), the decoded segments, and led_dp = ~CTRL[8+idx].
- Segment decode (a..g lit set):
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg
  - 4: bcfg; 5: acdfg; 6: acdefg; 7: abc
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg
  - C: adef; d: bcdeg; E: adefg; F: aefg
- Reset values:
  - DATA = 0x00000000; CTRL = 0x000000FF
  - cnt = 0, idx = 0
  - led_en = 8'hFF; led_ca..led_cg and led_dp = 1 (display dark)

## Timing
- All display outputs are registered. They are computed each cycle from current idx, DATA and CTRL, and appear one clk after any change to those values.
- After reset release: first edge loads outputs for digit 0. idx advances after SCAN_DIV cycles. A full refresh frame is 8×SCAN_DIV cycles.
- A write that changes the currently scanned digit is visible on the outputs one cycle after the write edge. No waiting for a frame boundary.
- A write on the same edge that idx advances: the outputs in the next cycle use the new idx and the new register value.
- Writes never disturb cnt or idx.
- rst_n asserted mid-scan: all state returns to reset values immediately (asynchronously), and outputs go dark without waiting for clk.
- rdata reflects a write on the cycle after the write edge.

## Configuration
- SEG7_LZ_SUPPRESS_EN defined: digit i (i ≥ 1) is blank when DATA[4i+3:4i] = 0 and every higher nibble is also 0. Digit 0 is never suppressed, so DATA = 0 shows a single "0".
- Undefined: all enabled digits show their nibble, including leading zeros. No suppression logic is synthesized.

## Test plan
- Reset with SCAN_DIV=4. Release rst_n and watch 40 cycles -> led_en cycles 0xFE,0xFD,...,0x7F, each for 4 cycles. Digits show "0", so segments a–f are low and g is high; led_dp=1.
- Write DATA=0x0123ABCF -> digit 0 shows F (a,e,f,g low), digit 1 shows C, digit 3 shows A. Without the macro, digit 7 shows 0; with SEG7_LZ_SUPPRESS_EN, digit 7 is dark (led_en=0xFF during its slot).
- Write CTRL=0x0000_0205 -> only digits 0 and 2 light. The dp is lit only on digit 1, which is disabled, so led_dp stays 1 throughout. rdata with sel=1 reads 0x00000205.
- Write CTRL bit16=1 mid-frame -> one cycle later led_en=0xFF and all segment lines are 1. Clearing bit16 resumes display at the current idx without a phase change.
- Write DATA while digit 0 is active -> new segments appear exactly one cycle after the write edge. The idx sequence is unchanged.
- Assert rst_n low between clk edges mid-scan -> outputs go dark immediately. After release, DATA reads 0 and CTRL reads 0xFF.
